// File: rtl/switch_debounce.sv
// Two-flop synchronizer plus per-bit debounce counter for the board slide switches.
// Latency SW->SW_DB/strobes is DEBOUNCE_CYCLES+2 edges; no backpressure, strobes are registered single-cycle pulses.
module switch_debounce #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] SW_DB,
  output logic [WIDTH-1:0] SW_RISE,
  output logic [WIDTH-1:0] SW_FALL,
  output logic             SW_CHANGE
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0] db_nxt;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;

  // Any edge where sync2 matches the accepted state discards the partial count.
  always_comb begin
    db_nxt   = SW_DB;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != SW_DB[i]) begin
        if (cnt[i] == CNT_MAX) begin
          db_nxt[i]   = sync2[i];
          rise_nxt[i] = sync2[i];
          fall_nxt[i] = ~sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1     <= '0;
      sync2     <= '0;
      SW_DB     <= '0;
      SW_RISE   <= '0;
      SW_FALL   <= '0;
      SW_CHANGE <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1     <= SW;
      sync2     <= sync1;
      SW_DB     <= db_nxt;
      SW_RISE   <= rise_nxt;
      SW_FALL   <= fall_nxt;
      SW_CHANGE <= |(rise_nxt | fall_nxt);
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce with DEBOUNCE_CYCLES=4: directed scenarios plus random bouncing,
// checked against a sample-history model (a change is accepted once the last D synchronized samples all disagree).
module tb_switch_debounce;
  localparam int W = 16;
  localparam int D = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw    = '0;
  logic [W-1:0] sw_db, sw_rise, sw_fall;
  logic         sw_change;
  int           tests = 0;
  int           fails = 0;

  switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .SW        (sw),
    .SW_DB     (sw_db),
    .SW_RISE   (sw_rise),
    .SW_FALL   (sw_fall),
    .SW_CHANGE (sw_change)
  );

  always #5 clk = ~clk;

  // Reference: raw samples since reset; the synchronized view at edge k is the raw sample of edge k-2.
  logic [W-1:0] samp [$];
  logic [W-1:0] seen [$];
  logic [W-1:0] m_db = '0, m_rise = '0, m_fall = '0, m_s2 = '0;
  logic         m_change = 1'b0;
  bit           m_ok;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp.delete();
      seen.delete();
      m_db = '0; m_rise = '0; m_fall = '0; m_change = 1'b0;
    end else begin
      m_s2 = (samp.size() >= 2) ? samp[samp.size()-2] : '0;
      samp.push_back(sw);
      if (samp.size() > 4) void'(samp.pop_front());
      seen.push_back(m_s2);
      if (seen.size() > D) void'(seen.pop_front());
      m_rise = '0;
      m_fall = '0;
      for (int b = 0; b < W; b++) begin
        m_ok = (seen.size() == D);
        foreach (seen[j]) if (seen[j][b] == m_db[b]) m_ok = 0;
        if (m_ok) begin
          m_db[b] = seen[D-1][b];
          if (seen[D-1][b]) m_rise[b] = 1'b1;
          else m_fall[b] = 1'b1;
        end
      end
      m_change = |(m_rise | m_fall);
    end
  end

  task automatic settle(input logic [W-1:0] v);
    sw = v;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw    = '1;
    repeat (3) @(negedge clk);
    tests++;
    if ({sw_db, sw_rise, sw_fall, sw_change} !== '0) begin
      fails++;
      $display("FAIL reset_hold: got db=%h rise=%h fall=%h chg=%b, want all 0", sw_db, sw_rise, sw_fall, sw_change);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tests++;
      if (sw_db !== ((k >= 5) ? 16'hFFFF : 16'h0000) || sw_rise !== ((k == 5) ? 16'hFFFF : 16'h0000) ||
          sw_fall !== 16'h0000 || sw_change !== (k == 5)) begin
        fails++;
        $display("FAIL reset_release k=%0d: got db=%h rise=%h fall=%h chg=%b", k, sw_db, sw_rise, sw_fall, sw_change);
      end
    end
  endtask

  task automatic test_clean_toggle();
    settle('0);
    sw = 16'h0008;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tests++;
      if (sw_rise !== ((k == 5) ? 16'h0008 : 16'h0000) || sw_db[3] !== (k >= 5) || sw_fall !== 16'h0000) begin
        fails++;
        $display("FAIL toggle_rise k=%0d: got db=%h rise=%h fall=%h", k, sw_db, sw_rise, sw_fall);
      end
    end
    sw = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tests++;
      if (sw_fall !== ((k == 5) ? 16'h0008 : 16'h0000) || sw_db[3] !== (k < 5) || sw_rise !== 16'h0000) begin
        fails++;
        $display("FAIL toggle_fall k=%0d: got db=%h rise=%h fall=%h", k, sw_db, sw_rise, sw_fall);
      end
      tests++;
      if ({sw_db, sw_rise, sw_fall, sw_change} !== {m_db, m_rise, m_fall, m_change}) begin
        fails++;
        $display("FAIL toggle_model k=%0d: got %h/%h/%h/%b want %h/%h/%h/%b", k,
                 sw_db, sw_rise, sw_fall, sw_change, m_db, m_rise, m_fall, m_change);
      end
    end
  endtask

  task automatic test_bounce();
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      tests++;
      if (sw_db[0] !== 1'b0 || sw_rise !== 16'h0000 || sw_fall !== 16'h0000 || sw_change !== 1'b0) begin
        fails++;
        $display("FAIL bounce j=%0d: got db=%h rise=%h fall=%h chg=%b", j, sw_db, sw_rise, sw_fall, sw_change);
      end
      sw[0] = (j < 8) ? (((j / 2) % 2) == 0) : 1'b0;
    end
  endtask

  task automatic test_glitch();
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      tests++;
      if (sw_rise !== ((j == 10) ? 16'h0080 : 16'h0000) || sw_db[7] !== (j >= 10) || sw_fall !== 16'h0000) begin
        fails++;
        $display("FAIL glitch j=%0d: got db=%h rise=%h fall=%h", j, sw_db, sw_rise, sw_fall);
      end
      sw[7] = (j != 3);
    end
  endtask

  task automatic test_simultaneous();
    settle('0);
    sw = 16'hA5A5;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tests++;
      if (sw_rise !== ((k == 5) ? 16'hA5A5 : 16'h0000) || sw_fall !== 16'h0000 ||
          sw_db !== ((k >= 5) ? 16'hA5A5 : 16'h0000) || sw_change !== (k == 5)) begin
        fails++;
        $display("FAIL simultaneous k=%0d: got db=%h rise=%h fall=%h chg=%b", k, sw_db, sw_rise, sw_fall, sw_change);
      end
    end
  endtask

  task automatic test_reset_mid();
    settle('0);
    sw = 16'h8000;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({sw_db, sw_rise, sw_fall, sw_change} !== '0) begin
      fails++;
      $display("FAIL reset_mid_async: got db=%h rise=%h fall=%h chg=%b, want all 0", sw_db, sw_rise, sw_fall, sw_change);
    end
    @(negedge clk);
    tests++;
    if ({sw_db, sw_rise, sw_fall, sw_change} !== '0) begin
      fails++;
      $display("FAIL reset_mid_hold: got db=%h rise=%h fall=%h chg=%b, want all 0", sw_db, sw_rise, sw_fall, sw_change);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tests++;
      if (sw_db[15] !== (k >= 5) || sw_rise !== ((k == 5) ? 16'h8000 : 16'h0000) || sw_fall !== 16'h0000) begin
        fails++;
        $display("FAIL reset_mid k=%0d: got db=%h rise=%h fall=%h", k, sw_db, sw_rise, sw_fall);
      end
    end
  endtask

  task automatic test_random();
    int idx;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      tests++;
      if ({sw_db, sw_rise, sw_fall, sw_change} !== {m_db, m_rise, m_fall, m_change} || (sw_rise & sw_fall) !== '0) begin
        fails++;
        $display("FAIL random n=%0d: got %h/%h/%h/%b want %h/%h/%h/%b", n,
                 sw_db, sw_rise, sw_fall, sw_change, m_db, m_rise, m_fall, m_change);
      end
      if ($urandom_range(3) == 0) begin
        idx = int'($urandom_range(3));
        sw[idx] = ~sw[idx];
      end
      if ($urandom_range(15) == 0) sw = sw ^ 16'($urandom);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(199) == 0) rst_n = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_clean_toggle();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Per-bit synchronizer and debouncer for the 16 board slide switches. It sits directly upstream of the switch-to-LED pass-through: raw `SW` pins enter here, and the clean `SW_DB` bus feeds the LED stage and any other logic that consumes switch state. It also emits single-cycle rise/fall strobes per switch so downstream counters and FSMs can react to toggles without their own edge detection.

## Interface
- `WIDTH`, 16: number of switch bits handled.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive clock edges a synchronized change must persist before it is accepted (10 ms at 100 MHz). Legal range is ≥1.
- `CNT_W`, `max(1, $clog2(DEBOUNCE_CYCLES))`: derived per-bit counter width. It is not overridden.
- `CLK100MHZ` input, 1: the single clock. All state is on its rising edge.
- `CPU_RESETN` input, 1: asynchronous, active-low reset.
- `SW` input, `WIDTH`: raw asynchronous switch pins.
- `SW_DB` output, `WIDTH`: debounced switch state.
- `SW_RISE` output, `WIDTH`: 1-cycle strobe when a `SW_DB` bit goes 0→1.
- `SW_FALL` output, `WIDTH`: 1-cycle strobe when a `SW_DB` bit goes 1→0.
- `SW_CHANGE` output, 1: OR-reduction of `SW_RISE | SW_FALL`, registered in the same cycle as the strobes.

## Operation
- **Synchronizer:** a two-flop chain per bit, `sync1 <= SW` then `sync2 <= sync1`. Only `sync2` is used downstream. Raw `SW` never touches any other logic.
- **Per-bit debounce state:** `cnt[i]` (`CNT_W` bits) and `db[i]` (drives `SW_DB[i]`). Bits are fully independent.
- **On each edge, per bit:**
  - If `sync2[i] == db[i]`: `cnt[i] <= 0`, with no strobe.
  - Else, if `cnt[i] == DEBOUNCE_CYCLES-1`: `db[i] <= sync2[i]`, `cnt[i] <= 0`, and assert `SW_RISE[i]` if `sync2[i]` is 1, otherwise `SW_FALL[i]`.
  - Else: `cnt[i] <= cnt[i] + 1`.
- A glitch shorter than `DEBOUNCE_CYCLES` edges resets the counter as soon as `sync2` returns to `db`. There is no partial credit: a following change restarts counting from 0.
- Strobes are registered. They are high for exactly one cycle, and otherwise 0.
- `SW_RISE[i]` and `SW_FALL[i]` are never high together.
- Different bits may strobe in the same cycle. `SW_CHANGE` is 1 in that cycle.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1`. No wrap-around is possible.
- With `DEBOUNCE_CYCLES` = 1, acceptance occurs on the first differing edge and `cnt` stays 0.

## Timing
- **Reset values:** while `CPU_RESETN` = 0, `sync1`, `sync2`, `cnt`, `SW_DB`, `SW_RISE`, `SW_FALL` and `SW_CHANGE` are all 0, asynchronously, regardless of clock.
- **Reset mid-operation:** all in-progress counts are discarded.
  - After deassertion, any switch held at 1 is treated as a new 0→1 change.
  - It produces `SW_RISE` after full latency.
- **Deassertion:** takes effect at the first rising edge after `CPU_RESETN` goes high.
- **Latency:** `SW[i]` changes and holds before edge E0.
  - `sync1` updates at E0 and `sync2` at E1.
  - The first differing edge is E2.
  - `SW_DB[i]` and the strobe update at edge E(`DEBOUNCE_CYCLES`+1), i.e. `DEBOUNCE_CYCLES`+2 edges after first sampling.
  - The strobe clears at the next edge.
- **Minimum accepted pulse width:** `DEBOUNCE_CYCLES` cycles as seen at `sync2`. Shorter pulses never reach `SW_DB`.
- **Output stability:** there is no combinational path from `SW` to any output. All outputs are flop outputs.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 unless noted.
- **Reset:** hold `CPU_RESETN` = 0 with `SW` = 16'hFFFF.
  - All outputs must be 0.
  - Release reset at edge R: `SW_DB` = 16'hFFFF after edge R+5, `SW_RISE` = 16'hFFFF for exactly that one cycle, and `SW_CHANGE` = 1 for that cycle.
- **Clean toggle:** `SW[3]` goes 0→1 before edge E0 and is held.
  - `SW_DB[3]` rises at E5, with `SW_RISE` = 16'h0008 for one cycle.
  - `SW[3]` then goes 1→0: `SW_FALL` = 16'h0008 after 6 edges.
- **Bounce rejection:** `SW[0]` toggles 1,0,1,0 at 2-cycle intervals, then holds 0.
  - `SW_DB[0]` stays 0 throughout.
  - No strobes are produced.
- **Glitch then settle:** `SW[7]` is high for 3 cycles, low for 1, then high and held.
  - `SW_DB[7]` rises exactly 6 edges after the final rising input.
  - No earlier strobe occurs.
- **Simultaneous bits:** `SW` goes 16'h0000→16'hA5A5 at once.
  - `SW_RISE` = 16'hA5A5 in a single cycle.
  - `SW_FALL` = 0.
  - `SW_DB` = 16'hA5A5 thereafter.
- **Reset mid-count:** `SW[15]` goes high, and `CPU_RESETN` is pulsed low 2 cycles later.
  - Outputs are 0 during reset.
  - `SW_DB[15]` rises 6 edges after deassertion, not earlier.
